// File: rtl/ysyx_22040237_fetch_ctrl.sv
// Fetch/execute sequencer for the single-cycle RV64 core.
// Each instruction goes through FETCH (request handshake), WAIT (response),
// EXEC (one-cycle commit pulse). The core stops for good on ebreak, an illegal
// instruction or a misaligned PC, until the next reset.
// Optional feature: define YSYX_22040237_FETCH_TIMEOUT_EN to bound the WAIT state;
// a memory that stays silent for TIMEOUT cycles then halts the core with cause 3.
module ysyx_22040237_fetch_ctrl #(
  parameter int          CNT_W    = 64,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_in,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic [31:0]      inst_out,
  output logic             core_step_en,
  input  logic             ebreak_in,
  input  logic             invalid_inst_in,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
  localparam logic [1:0] CAUSE_INVALID = 2'd2;
  localparam logic [1:0] CAUSE_ADDR    = 2'd3;

  state_t      state;
  logic [31:0] addr_q;
  logic        pc_misaligned;
  logic        fetch_go;
  logic        cnt_full;

  // The request must be visible in the very first FETCH cycle (3 cycles per
  // instruction with a zero-wait memory), and pc_in only settles on the edge
  // that enters FETCH, so valid/addr are decoded from state rather than
  // registered. pc_in cannot move while we sit in FETCH, which keeps the
  // address stable until the handshake completes.
  assign pc_misaligned  = (pc_in[1:0] != 2'b00);
  assign fetch_go       = (state == S_FETCH) && !pc_misaligned;
  assign cnt_full       = &retired_cnt;

  assign imem_req_valid = fetch_go;
  assign imem_req_addr  = fetch_go ? pc_in : addr_q;
  // The decoder flags are only known during EXEC, so the commit pulse is
  // gated combinationally: an illegal instruction must never commit.
  assign core_step_en   = (state == S_EXEC) && !invalid_inst_in;

`ifdef YSYX_22040237_FETCH_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
  logic       wait_expired;
  assign wait_expired = (wait_cnt == WAIT_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Sequencer: state, held instruction, last fetch address and halt status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      inst_out   <= NOP_INST;
      halted     <= 1'b0;
      halt_cause <= 2'd0;
`ifdef YSYX_22040237_FETCH_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (pc_misaligned) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            halt_cause <= CAUSE_ADDR;
          end else if (imem_req_ready) begin
            state  <= S_WAIT;
            addr_q <= pc_in;
`ifdef YSYX_22040237_FETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            inst_out <= imem_rsp_data;
            state    <= S_EXEC;
          end
`ifdef YSYX_22040237_FETCH_TIMEOUT_EN
          else if (wait_expired) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            halt_cause <= CAUSE_ADDR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        S_EXEC: begin
          if (invalid_inst_in) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            halt_cause <= CAUSE_INVALID;
          end else if (ebreak_in) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            halt_cause <= CAUSE_EBREAK;
          end else begin
            state <= S_FETCH;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

  // Retired-instruction counter, sticks at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (core_step_en && !cnt_full) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_fetch_ctrl.sv
// Self-checking bench for ysyx_22040237_fetch_ctrl: a reactive memory and PC
// register drive the sequencer, a behavioural model predicts every output each
// cycle, and directed scenarios pin key values with hand-computed literals.
module tb_ysyx_22040237_fetch_ctrl;

  localparam int               CNT_W   = 4;
  localparam int               TIMEOUT = 255;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]      NOP     = 32'h00000013;
  localparam logic [31:0]      STALE   = 32'hDEADBEEF;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      pc_in;
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [31:0]      imem_req_addr;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;
  logic [31:0]      inst_out;
  logic             core_step_en;
  logic             ebreak_in;
  logic             invalid_inst_in;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] retired_cnt;

  ysyx_22040237_fetch_ctrl #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .NOP_INST(NOP)
  ) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_out(inst_out),
    .core_step_en(core_step_en), .ebreak_in(ebreak_in),
    .invalid_inst_in(invalid_inst_in), .halted(halted),
    .halt_cause(halt_cause), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // environment knobs
  int          ready_hold;
  int          rsp_lat;
  logic        flush_pend;
  logic        pc_reload;
  logic [31:0] pc_reload_val;
  int          stale_sent;

  // observations taken on the falling edge
  logic        s_step, s_hs;
  logic [31:0] s_addr;
  int          cyc, steps, hs_count, valid_cycles, stall_cycles, addr_changes;
  int          first_step_cyc, second_step_cyc;
  logic [31:0] first_hs_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h80000000) return 32'h00100093;
    return a ^ 32'h0F0F0013;
  endfunction

  // ---------------- behavioural model ----------------
  // Lifecycle of one instruction: idle once after reset, request, response,
  // execute; a halt is absorbing. Commits are counted without bound and the
  // saturation is applied when the expected output is formed.
  localparam int P_IDLE = 0, P_FETCH = 1, P_WAIT = 2, P_EXEC = 3, P_HALT = 4;
  int          m_ph;
  int          m_commits;
  logic [31:0] m_inst, m_addr;
  logic        m_halted;
  logic [1:0]  m_cause;
`ifdef YSYX_22040237_FETCH_TIMEOUT_EN
  int          m_waited;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= P_IDLE; m_commits <= 0; m_inst <= NOP; m_addr <= '0;
      m_halted <= 1'b0; m_cause <= 2'd0;
`ifdef YSYX_22040237_FETCH_TIMEOUT_EN
      m_waited <= 0;
`endif
    end else if (m_ph == P_IDLE) begin
      m_ph <= P_FETCH;
    end else if (m_ph == P_FETCH) begin
      if (pc_in[1:0] != 2'b00) begin
        m_ph <= P_HALT; m_halted <= 1'b1; m_cause <= 2'd3;
      end else if (imem_req_ready) begin
        m_ph <= P_WAIT; m_addr <= pc_in;
`ifdef YSYX_22040237_FETCH_TIMEOUT_EN
        m_waited <= 0;
`endif
      end
    end else if (m_ph == P_WAIT) begin
      if (imem_rsp_valid) begin
        m_ph <= P_EXEC; m_inst <= imem_rsp_data;
      end
`ifdef YSYX_22040237_FETCH_TIMEOUT_EN
      else if (m_waited + 1 >= TIMEOUT) begin
        m_ph <= P_HALT; m_halted <= 1'b1; m_cause <= 2'd3;
      end else begin
        m_waited <= m_waited + 1;
      end
`endif
    end else if (m_ph == P_EXEC) begin
      if (invalid_inst_in) begin
        m_ph <= P_HALT; m_halted <= 1'b1; m_cause <= 2'd2;
      end else begin
        m_commits <= m_commits + 1;
        if (ebreak_in) begin
          m_ph <= P_HALT; m_halted <= 1'b1; m_cause <= 2'd1;
        end else begin
          m_ph <= P_FETCH;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // memory + PC register: reacts one delta region after each rising edge
  task automatic env_loop();
    int          vcnt = 0;
    int          lat_left = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pc_reload) pc_in = pc_reload_val;
      else if (s_step) pc_in = pc_in + 32'd4;
      if (s_hs) begin
        pend = 1'b1; lat_left = rsp_lat; pend_data = mem_word(s_addr);
      end
      if (rst && pend) pend_data = STALE;
      if (flush_pend) pend = 1'b0;
      if (pend && lat_left <= 1) begin
        imem_rsp_valid = 1'b1; imem_rsp_data = pend_data; pend = 1'b0;
        if (pend_data == STALE) stale_sent++;
      end else begin
        imem_rsp_valid = 1'b0;
        if (pend) lat_left--;
      end
      #1;
      if (imem_req_valid) begin
        imem_req_ready = (vcnt >= ready_hold);
        vcnt++;
      end else begin
        imem_req_ready = 1'b0;
        vcnt = 0;
      end
    end
  endtask

  // per-cycle comparison of every output against the model
  task automatic mon_loop();
    logic             exp_valid, exp_step, prev_valid;
    logic [31:0]      exp_addr, prev_addr;
    logic [CNT_W-1:0] exp_cnt;
    int               shown = 0;
    prev_valid = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      exp_valid = (m_ph == P_FETCH) && (pc_in[1:0] == 2'b00);
      exp_step  = (m_ph == P_EXEC) && !invalid_inst_in;
      exp_addr  = exp_valid ? pc_in : m_addr;
      exp_cnt   = (m_commits >= int'(CNT_MAX)) ? CNT_MAX : CNT_W'(m_commits);
      total++;
      if (imem_req_valid !== exp_valid || imem_req_addr !== exp_addr ||
          inst_out !== m_inst || core_step_en !== exp_step || halted !== m_halted ||
          halt_cause !== m_cause || retired_cnt !== exp_cnt) begin
        bad++;
        if (shown < 20) begin
          shown++;
          $display("FAIL cycle %0d: valid %b/%b addr %h/%h inst %h/%h step %b/%b halted %b/%b cause %0d/%0d cnt %0d/%0d (got/want)",
                   cyc, imem_req_valid, exp_valid, imem_req_addr, exp_addr, inst_out, m_inst,
                   core_step_en, exp_step, halted, m_halted, halt_cause, m_cause, retired_cnt, exp_cnt);
        end
      end
      s_step = core_step_en;
      s_hs   = imem_req_valid && imem_req_ready;
      s_addr = imem_req_addr;
      if (rst) begin
        steps = 0; hs_count = 0; valid_cycles = 0; stall_cycles = 0; addr_changes = 0;
        first_step_cyc = 0; second_step_cyc = 0; first_hs_addr = '0;
        prev_valid = 1'b0;
      end else begin
        if (core_step_en) begin
          steps++;
          if (steps == 1) first_step_cyc = cyc;
          if (steps == 2) second_step_cyc = cyc;
        end
        if (imem_req_valid) valid_cycles++;
        if (imem_req_valid && !imem_req_ready) stall_cycles++;
        if (imem_req_valid && prev_valid && imem_req_addr != prev_addr) addr_changes++;
        if (s_hs) begin
          hs_count++;
          if (hs_count == 1) first_hs_addr = imem_req_addr;
        end
        prev_valid = imem_req_valid;
        prev_addr  = imem_req_addr;
      end
    end
  endtask

  task automatic do_reset(input logic [31:0] pc);
    rst = 1'b1; flush_pend = 1'b1; pc_reload = 1'b1; pc_reload_val = pc;
    tick();
    tick();
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr", 64'(imem_req_addr), 64'd0);
    check("rst_inst_out", 64'(inst_out), 64'(NOP));
    check("rst_step_en", 64'(core_step_en), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_cause", 64'(halt_cause), 64'd0);
    check("rst_retired", 64'(retired_cnt), 64'd0);
    flush_pend = 1'b0; pc_reload = 1'b0; rst = 1'b0;
  endtask

  task automatic wait_steps(input int n, input int budget);
    for (int i = 0; i < budget && steps < n; i++) tick();
    check("wait_steps", 64'(steps >= n), 64'd1);
  endtask

  task automatic wait_hs(input int budget);
    for (int i = 0; i < budget && hs_count < 1; i++) tick();
    check("wait_handshake", 64'(hs_count >= 1), 64'd1);
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !m_halted; i++) tick();
    check("wait_halt", 64'(m_halted), 64'd1);
  endtask

  initial begin
    rst = 1'b1; ebreak_in = 1'b0; invalid_inst_in = 1'b0;
    ready_hold = 0; rsp_lat = 1; flush_pend = 1'b1; pc_reload = 1'b1;
    pc_reload_val = 32'h80000000; pc_in = 32'h80000000; stale_sent = 0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    s_step = 1'b0; s_hs = 1'b0; s_addr = '0; cyc = 0;
    steps = 0; hs_count = 0; valid_cycles = 0; stall_cycles = 0; addr_changes = 0;
    first_step_cyc = 0; second_step_cyc = 0; first_hs_addr = '0;
    fork
      env_loop();
      mon_loop();
    join_none

    // 1: zero-wait memory, first instruction, throughput, counter saturation
    do_reset(32'h80000000);
    wait_steps(1, 30);
    check("t1_inst_out", 64'(inst_out), 64'h00100093);
    check("t1_req_addr", 64'(first_hs_addr), 64'h80000000);
    check("t1_retired", 64'(retired_cnt), 64'd1);
    wait_steps(2, 30);
    check("t1_cycles_per_inst", 64'(second_step_cyc - first_step_cyc), 64'd3);
    wait_steps(18, 120);
    check("t1_saturated", 64'(retired_cnt), 64'hF);

    // 2: ready held low for 4 cycles
    ready_hold = 4; rsp_lat = 2;
    do_reset(32'h80000100);
    wait_hs(30);
    check("t2_stall_cycles", 64'(stall_cycles), 64'd4);
    check("t2_valid_cycles", 64'(valid_cycles), 64'd5);
    check("t2_addr_changes", 64'(addr_changes), 64'd0);
    check("t2_req_addr", 64'(first_hs_addr), 64'h80000100);
    wait_steps(1, 30);
    check("t2_inst_out", 64'(inst_out), 64'(mem_word(32'h80000100)));
    check("t2_retired", 64'(retired_cnt), 64'd1);

    // 3: ebreak retires and halts
    ready_hold = 0; rsp_lat = 1; ebreak_in = 1'b1;
    do_reset(32'h80000000);
    wait_halt(30);
    repeat (10) tick();
    check("t3_halted", 64'(halted), 64'd1);
    check("t3_cause", 64'(halt_cause), 64'd1);
    check("t3_retired", 64'(retired_cnt), 64'd1);
    check("t3_steps", 64'(steps), 64'd1);
    check("t3_valid_cycles", 64'(valid_cycles), 64'd1);

    // 4: invalid wins over ebreak, no commit
    invalid_inst_in = 1'b1;
    do_reset(32'h80000000);
    wait_halt(30);
    repeat (5) tick();
    check("t4_cause", 64'(halt_cause), 64'd2);
    check("t4_retired", 64'(retired_cnt), 64'd0);
    check("t4_steps", 64'(steps), 64'd0);

    // 5: misaligned PC halts without a request
    ebreak_in = 1'b0; invalid_inst_in = 1'b0;
    do_reset(32'h80000002);
    repeat (10) tick();
    check("t5_halted", 64'(halted), 64'd1);
    check("t5_cause", 64'(halt_cause), 64'd3);
    check("t5_valid_cycles", 64'(valid_cycles), 64'd0);

    // 6: reset during WAIT, stale response lands in FETCH and is ignored
    ebreak_in = 1'b1; ready_hold = 3; rsp_lat = 6;
    do_reset(32'h80000000);
    wait_hs(30);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wait_halt(60);
    check("t6_stale_delivered", 64'(stale_sent), 64'd1);
    check("t6_inst_out", 64'(inst_out), 64'h00100093);
    check("t6_new_fetch", 64'(hs_count), 64'd1);
    check("t6_cause", 64'(halt_cause), 64'd1);
    check("t6_retired", 64'(retired_cnt), 64'd1);

    // 6b: response withheld
    ebreak_in = 1'b0; ready_hold = 0; rsp_lat = 100000;
    do_reset(32'h80000000);
    repeat (300) tick();
`ifdef YSYX_22040237_FETCH_TIMEOUT_EN
    check("t6_timeout_halted", 64'(halted), 64'd1);
    check("t6_timeout_cause", 64'(halt_cause), 64'd3);
`else
    check("t6_wait_forever", 64'(halted), 64'd0);
    check("t6_wait_cause", 64'(halt_cause), 64'd0);
`endif
    check("t6_wait_retired", 64'(retired_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
